// File: rtl/w5300_bus_arbiter_if.sv
// Requester and W5300-side signals of the two-master bus arbiter.
// slave = the arbiter itself; master = requesters plus W5300 interface model.
interface w5300_bus_arbiter_if;
  logic        m0_req;
  logic [10:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic        m0_err;
  logic [15:0] m0_rdata;

  logic        m1_req;
  logic [10:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic        m1_err;
  logic [15:0] m1_rdata;

  logic [11:0] uaddr;
  logic [15:0] u_wr_data;
  logic [15:0] u_rd_data;
  logic        op_status;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m1_req, m1_addr, m1_wdata,
    input  u_rd_data, op_status,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output uaddr, u_wr_data, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m1_req, m1_addr, m1_wdata,
    output u_rd_data, op_status,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  uaddr, u_wr_data, busy
  );
endinterface

// File: rtl/w5300_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the W5300 bus: one access at a time, gnt/done one cycle after
// the accepting/completing edge; requests are only sampled in IDLE (no queueing), WAIT ends on op_status or timeout.
module w5300_bus_arbiter #(
  parameter int STARTUP_CYCLES = 5300,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  w5300_bus_arbiter_if.slave  bus
);

  localparam logic [15:0] INIT_LAST    = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic        r_ptr, w_ptr;
  logic        r_owner, w_owner;
  logic [11:0] r_uaddr, w_uaddr;
  logic [15:0] r_wr_data, w_wr_data;
  logic [1:0]  r_gnt, w_gnt;
  logic [1:0]  r_done, w_done;
  logic [1:0]  r_err, w_err;
  logic [15:0] r_rdata [2];
  logic [15:0] w_rdata [2];
  logic        w_win;
  logic        w_any_req;

  // Contention goes to the pointer; a lone requester always wins.
  assign w_any_req = bus.m0_req | bus.m1_req;
  assign w_win     = (bus.m0_req && bus.m1_req) ? r_ptr : bus.m1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_cnt     <= 16'd0;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_uaddr   <= 12'h800;
      r_wr_data <= 16'h0000;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      r_rdata   <= '{16'h0000, 16'h0000};
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_ptr     <= w_ptr;
      r_owner   <= w_owner;
      r_uaddr   <= w_uaddr;
      r_wr_data <= w_wr_data;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_err     <= w_err;
      r_rdata   <= w_rdata;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + 16'd1;
    w_ptr     = r_ptr;
    w_owner   = r_owner;
    w_uaddr   = r_uaddr;
    w_wr_data = r_wr_data;
    w_gnt     = 2'b00;
    w_done    = 2'b00;
    w_err     = 2'b00;
    w_rdata   = r_rdata;

    unique case (r_state)
      ST_INIT: begin
        if (r_cnt == INIT_LAST) begin
          w_state = ST_IDLE;
          w_cnt   = 16'd0;
        end
      end

      ST_IDLE: begin
        w_cnt = 16'd0;
        if (w_any_req) begin
          w_state        = ST_WAIT;
          w_owner        = w_win;
          w_ptr          = ~w_win;
          w_uaddr        = {1'b0, (w_win ? bus.m1_addr : bus.m0_addr)};
          w_wr_data      = w_win ? bus.m1_wdata : bus.m0_wdata;
          w_gnt[w_win]   = 1'b1;
        end
      end

      ST_WAIT: begin
        // op_status is checked first so a completion on the terminal cycle is not reported as a timeout.
        if (bus.op_status) begin
          w_state          = ST_GAP;
          w_cnt            = 16'd0;
          w_uaddr[11]      = 1'b1;
          w_done[r_owner]  = 1'b1;
          w_rdata[r_owner] = bus.u_rd_data;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state          = ST_GAP;
          w_cnt            = 16'd0;
          w_uaddr[11]      = 1'b1;
          w_done[r_owner]  = 1'b1;
          w_err[r_owner]   = 1'b1;
          w_rdata[r_owner] = 16'h0000;
        end
      end

      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state = ST_IDLE;
          w_cnt   = 16'd0;
        end
      end

      default: begin
        w_state = ST_INIT;
        w_cnt   = 16'd0;
      end
    endcase
  end

  assign bus.m0_gnt    = r_gnt[0];
  assign bus.m1_gnt    = r_gnt[1];
  assign bus.m0_done   = r_done[0];
  assign bus.m1_done   = r_done[1];
  assign bus.m0_err    = r_err[0];
  assign bus.m1_err    = r_err[1];
  assign bus.m0_rdata  = r_rdata[0];
  assign bus.m1_rdata  = r_rdata[1];
  assign bus.uaddr     = r_uaddr;
  assign bus.u_wr_data = r_wr_data;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter at default parameters: startup, read, timeout, boundary, reset, contention.
module tb_w5300_bus_arbiter;

  localparam int S = 5300;
  localparam int T = 1024;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  w5300_bus_arbiter_if bus ();

  w5300_bus_arbiter #(
    .STARTUP_CYCLES (S),
    .TIMEOUT_CYCLES (T),
    .GAP_CYCLES     (G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int bound, output int who, output int cycles);
    who = -1;
    cycles = 0;
    while (cycles < bound && who < 0) begin
      tick();
      cycles++;
      if (bus.m0_gnt) who = 0;
      else if (bus.m1_gnt) who = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  who, cyc;
    bit  ok;
    logic [15:0] rd;

    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.u_rd_data = '0; bus.op_status = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_uaddr", 32'(bus.uaddr), 32'h800);
    chk("rst_wr_data", 32'(bus.u_wr_data), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_pulses", {26'b0, bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 32'h0);
    chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 32'h0);

    // Startup: m0 requesting from release, grant exactly S+1 edges later
    bus.m0_req = 1'b1; bus.m0_addr = 11'h20C; bus.m0_wdata = 16'h1234;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= S; k++) begin
      tick();
      if (bus.m0_gnt || bus.m1_gnt || !bus.uaddr[11]) ok = 1'b0;
    end
    chk("startup_quiet", 32'(ok), 32'h1);
    tick();
    chk("startup_gnt", 32'(bus.m0_gnt), 32'h1);
    chk("read_uaddr", 32'(bus.uaddr), 32'h20C);
    chk("read_wr_data", 32'(bus.u_wr_data), 32'h1234);
    bus.m0_req = 1'b0;

    // Single read, op_status sampled on the 5th edge after the grant
    ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.m0_done || bus.uaddr != 12'h20C || bus.u_wr_data != 16'h1234) ok = 1'b0;
    end
    chk("read_wait_stable", 32'(ok), 32'h1);
    bus.op_status = 1'b1; bus.u_rd_data = 16'hA5A5;
    tick();
    bus.op_status = 1'b0; bus.u_rd_data = 16'h0000;
    chk("read_done", 32'(bus.m0_done), 32'h1);
    chk("read_err", 32'(bus.m0_err), 32'h0);
    chk("read_rdata", 32'(bus.m0_rdata), 32'hA5A5);
    chk("read_gap_uaddr0", 32'(bus.uaddr), 32'hA0C);
    tick();
    chk("read_done_pulse", 32'(bus.m0_done), 32'h0);
    chk("read_gap_uaddr1", 32'(bus.uaddr), 32'hA0C);
    chk("read_gap_busy", 32'(bus.busy), 32'h1);
    chk("read_rdata_hold", 32'(bus.m0_rdata), 32'hA5A5);
    tick();
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Timeout on m1
    bus.m1_req = 1'b1; bus.m1_addr = 11'h055; bus.m1_wdata = 16'hBEEF;
    wait_gnt(20, who, cyc);
    chk("to_who", 32'(who), 32'h1);
    chk("to_gnt_latency", 32'(cyc), 32'h1);
    chk("to_uaddr", 32'(bus.uaddr), 32'h055);
    chk("to_wr_data", 32'(bus.u_wr_data), 32'hBEEF);
    bus.m1_req = 1'b0;
    ok = 1'b1;
    for (int k = 1; k < T; k++) begin
      tick();
      if (bus.m1_done || bus.m0_done) ok = 1'b0;
    end
    chk("to_no_early_done", 32'(ok), 32'h1);
    tick();
    chk("to_done", 32'(bus.m1_done), 32'h1);
    chk("to_err", 32'(bus.m1_err), 32'h1);
    chk("to_rdata", 32'(bus.m1_rdata), 32'h0);
    chk("to_gap_uaddr", 32'(bus.uaddr), 32'h855);

    // Next request after timeout: GAP then accept
    bus.m0_req = 1'b1; bus.m0_addr = 11'h7FF; bus.m0_wdata = 16'h0F0F;
    wait_gnt(20, who, cyc);
    chk("post_to_who", 32'(who), 32'h0);
    chk("post_to_latency", 32'(cyc), 32'(G + 1));
    chk("post_to_uaddr", 32'(bus.uaddr), 32'h7FF);
    bus.m0_req = 1'b0;

    // Boundary: op_status on the terminal timeout cycle wins
    for (int k = 1; k < T; k++) tick();
    chk("bnd_no_done_yet", 32'(bus.m0_done), 32'h0);
    bus.op_status = 1'b1; bus.u_rd_data = 16'h5A3C;
    tick();
    bus.op_status = 1'b0; bus.u_rd_data = 16'h0000;
    chk("bnd_done", 32'(bus.m0_done), 32'h1);
    chk("bnd_err", 32'(bus.m0_err), 32'h0);
    chk("bnd_rdata", 32'(bus.m0_rdata), 32'h5A3C);
    chk("bnd_m1_err_clear", 32'(bus.m1_err), 32'h0);

    // Reset in the middle of WAIT
    bus.m1_req = 1'b1; bus.m1_addr = 11'h123; bus.m1_wdata = 16'h4321;
    wait_gnt(20, who, cyc);
    chk("rw_who", 32'(who), 32'h1);
    bus.m1_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rw_async_uaddr", 32'(bus.uaddr), 32'h800);
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.m0_done || bus.m1_done) ok = 1'b0;
    end
    chk("rw_uaddr", 32'(bus.uaddr), 32'h800);
    chk("rw_wr_data", 32'(bus.u_wr_data), 32'h0);
    chk("rw_busy", 32'(bus.busy), 32'h1);
    chk("rw_rdata", {bus.m0_rdata, bus.m1_rdata}, 32'h0);
    chk("rw_pulses", {26'b0, bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 32'h0);

    // Restart, then contention: pointer back at m0, order m0,m1,m0,m1
    bus.m0_req = 1'b1; bus.m0_addr = 11'h100; bus.m0_wdata = 16'hAAAA;
    bus.m1_req = 1'b1; bus.m1_addr = 11'h200; bus.m1_wdata = 16'h5555;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(S + 20, who, cyc);
      if (i == 0) begin
        chk("rw_done_free", 32'(ok), 32'h1);
        chk("restart_latency", 32'(cyc), 32'(S + 1));
      end else begin
        chk("ct_latency", 32'(cyc), 32'(G + 1));
      end
      chk("ct_order", 32'(who), 32'(i % 2));
      chk("ct_onehot", 32'(bus.m0_gnt & bus.m1_gnt), 32'h0);
      chk("ct_uaddr", 32'(bus.uaddr), (i % 2 == 0) ? 32'h100 : 32'h200);
      if (i == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      tick();
      rd = 16'h1000 + 16'(i);
      bus.op_status = 1'b1; bus.u_rd_data = rd;
      tick();
      bus.op_status = 1'b0; bus.u_rd_data = 16'h0000;
      chk("ct_done", {30'b0, bus.m1_done, bus.m0_done}, (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("ct_rdata", 32'((i % 2 == 0) ? bus.m0_rdata : bus.m1_rdata), 32'(rd));
    end

    // No further grant once both requests drop
    wait_gnt(10, who, cyc);
    chk("ct_no_extra_gnt", 32'(who), 32'hFFFF_FFFF);
    chk("ct_final_busy", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
